lut_layer_sequencer: RTL and testbench

Time-multiplexed evaluator for one layer of LUT neurons. Each neuron has an 8-input fan-in and a 1-bit output. Instead of instantiating one hard-coded truth-table ROM per neuron, the block holds every neuron's fan-in indices and truth table in programmable distributed RAM. It evaluates the layer one neuron per cycle under an FSM, with valid/ready handshakes on the activation vector in and out. It sits between two layer stages of the network pipeline, where area matters more than throughput.

---
 rtl/lut_layer_sequencer_if.sv | 24 ++
 rtl/lut_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_lut_layer_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_sequencer_if.sv
// Activation handshake bundle for lut_layer_sequencer.
// The master side drives the input vector and consumes the result.
// The slave side is the sequencer itself.
interface lut_layer_sequencer_if #(
    parameter int IN_BITS = 128,
    parameter int NEURONS = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_BITS-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NEURONS-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one layer of 8-input LUT neurons.
// Fan-in indices and truth tables live in programmable distributed RAM.
// The layer is evaluated one neuron per cycle through a two-stage
// gather/lookup pipeline.
// Optional macro LUT_SEQ_CFG_LOCK_EN: drops config writes issued during
// EVAL/DRAIN and flags each one with a single-cycle cfg_err pulse.
module lut_layer_sequencer #(
    parameter int NEURONS = 64,
    parameter int IN_BITS = 128,
    parameter int FANIN   = 8,
    parameter int IDX_W   = $clog2(IN_BITS),
    parameter int N_W     = $clog2(NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst,
    lut_layer_sequencer_if.slave     io,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [N_W-1:0]           cfg_neuron,
    input  logic [FANIN-1:0]         cfg_addr,
    input  logic [IDX_W-1:0]         cfg_wdata,
    output logic                     busy,
    output logic                     cfg_err
);
    localparam int DEPTH  = 1 << FANIN;
    localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, DRAIN, HOLD} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx_mem [NEURONS][FANIN];
    logic [DEPTH-1:0]     tbl_mem [NEURONS];
    logic [IN_BITS-1:0]   in_reg;
    logic [N_W-1:0]       n;
    logic [N_W-1:0]       n_d;
    logic [FANIN-1:0]     addr;
    logic [FANIN-1:0]     addr_d;
    logic                 d_valid;
    logic [NEURONS-1:0]   work;
    logic                 wr_ok;

    // Write gate: with the lock enabled, writes only land while no inference is in flight.
`ifdef LUT_SEQ_CFG_LOCK_EN
    assign wr_ok = cfg_we && (state == IDLE || state == HOLD);
`else
    assign wr_ok = cfg_we;
`endif

    // Stage 1 gather: each slot picks one input bit; out-of-range indices fall back to bit 0.
    always_comb begin
        addr = '0;
        for (int unsigned k = 0; k < FANIN; k++) begin
            if (int'(idx_mem[n][k]) < IN_BITS)
                addr[k] = in_reg[idx_mem[n][k]];
            else
                addr[k] = in_reg[0];
        end
    end

    // Configuration RAM writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (cfg_sel)
                tbl_mem[cfg_neuron][cfg_addr] <= cfg_wdata[0];
            else if (int'(cfg_addr) < FANIN)
                idx_mem[cfg_neuron][cfg_addr[SLOT_W-1:0]] <= cfg_wdata;
        end
    end

    // Sequencer FSM with registered handshake/status outputs.
    // DRAIN spends one cycle finishing the last lookup and one cycle copying
    // the completed work vector, so out_data never shows a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
            n            <= '0;
            n_d          <= '0;
            addr_d       <= '0;
            d_valid      <= 1'b0;
            work         <= '0;
            in_reg       <= '0;
        end else begin
`ifdef LUT_SEQ_CFG_LOCK_EN
            cfg_err <= cfg_we && (state == EVAL || state == DRAIN);
`else
            cfg_err <= 1'b0;
`endif
            d_valid <= 1'b0;
            if (d_valid)
                work[n_d] <= tbl_mem[n_d][addr_d];

            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        in_reg      <= io.in_data;
                        n           <= '0;
                        io.in_ready <= 1'b0;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    busy    <= 1'b1;
                    addr_d  <= addr;
                    n_d     <= n;
                    d_valid <= 1'b1;
                    if (n == N_W'(NEURONS - 1))
                        state <= DRAIN;
                    else
                        n <= n + 1'b1;
                end
                DRAIN: begin
                    if (!d_valid) begin
                        io.out_data  <= work;
                        io.out_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: fixed vector table, random
// vectors against a truth-table reference model, and hand-written timing,
// back-pressure, config-lock and mid-run reset sequences.
module tb_lut_layer_sequencer;
    localparam int NEURONS = 64;
    localparam int IN_BITS = 128;
    localparam int FANIN   = 8;
    localparam int IDX_W   = 7;
    localparam int N_W     = 6;
    localparam int DEPTH   = 256;

    logic clk = 1'b0;
    logic rst;
    logic cfg_we, cfg_sel;
    logic [N_W-1:0]   cfg_neuron;
    logic [FANIN-1:0] cfg_addr;
    logic [IDX_W-1:0] cfg_wdata;
    logic busy, cfg_err;

    always #5 clk = ~clk;

    lut_layer_sequencer_if #(.IN_BITS(IN_BITS), .NEURONS(NEURONS)) bus ();

    lut_layer_sequencer #(
        .NEURONS(NEURONS),
        .IN_BITS(IN_BITS),
        .FANIN(FANIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy(busy),
        .cfg_err(cfg_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference configuration as programmed by the bench.
    int m_idx [NEURONS][FANIN];
    bit m_tbl [NEURONS][DEPTH];

    typedef struct {
        logic [IN_BITS-1:0] vin;
        logic [4:0]         exp;  // {identity neuron 4, parity neurons 3..0}
    } vec_t;
    vec_t tv [6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [NEURONS-1:0] model(input logic [IN_BITS-1:0] v);
        logic [NEURONS-1:0] r;
        int a, j;
        r = '0;
        for (int nn = 0; nn < NEURONS; nn++) begin
            a = 0;
            for (int k = 0; k < FANIN; k++) begin
                j = m_idx[nn][k];
                if (j < IN_BITS) a += int'(v[j]) << k;
                else             a += int'(v[0]) << k;
            end
            r[nn] = m_tbl[nn][a];
        end
        return r;
    endfunction

    task automatic cfg_wr(input logic sel, input int nn, input int addr, input int data);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_sel    = sel;
        cfg_neuron = N_W'(nn);
        cfg_addr   = FANIN'(addr);
        cfg_wdata  = IDX_W'(data);
    endtask

    task automatic cfg_done();
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int t;
        t = 0;
        while (!bus.out_valid && t < NEURONS + 20) begin
            @(negedge clk);
            t++;
        end
        check(name, 128'(bus.out_valid), 128'd1);
    endtask

    task automatic infer(input logic [IN_BITS-1:0] v, output logic [NEURONS-1:0] r);
        int t;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = v;
        bus.out_ready = 1'b0;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out("infer_timeout");
        r = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NEURONS-1:0] r, exp_r;
        logic [IN_BITS-1:0] v, v2;
        logic [3:0] par;
        int busy_cnt, first_busy, first_ov, irdy_bad, stable_bad;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0;
        #12;
        check("rst_in_ready",  128'(bus.in_ready),  128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data",  128'(bus.out_data),  128'd0);
        check("rst_busy",      128'(busy),          128'd0);
        check("rst_cfg_err",   128'(cfg_err),       128'd0);
        @(negedge clk); rst = 1'b0;

        // Neurons 0..3: parity over byte k; neuron 4: identity on bit 5; rest random.
        for (int nn = 0; nn < NEURONS; nn++) begin
            for (int k = 0; k < FANIN; k++) begin
                if (nn < 4)       m_idx[nn][k] = 8 * nn + k;
                else if (nn == 4) m_idx[nn][k] = 5;
                else              m_idx[nn][k] = int'($urandom_range(0, IN_BITS - 1));
                cfg_wr(1'b0, nn, k, m_idx[nn][k]);
            end
            for (int a = 0; a < DEPTH; a++) begin
                logic [7:0] ab;
                ab = 8'(a);
                if (nn < 4)       m_tbl[nn][a] = ^ab;
                else if (nn == 4) m_tbl[nn][a] = (a == DEPTH - 1);
                else              m_tbl[nn][a] = 1'($urandom);
                cfg_wr(1'b1, nn, a, int'(m_tbl[nn][a]));
            end
        end
        cfg_done();

        tv[0] = '{vin: 128'h0,           exp: 5'b00000};
        tv[1] = '{vin: 128'h20,          exp: 5'b10001};
        tv[2] = '{vin: 128'h01,          exp: 5'b00001};
        tv[3] = '{vin: 128'hFF,          exp: 5'b10000};
        tv[4] = '{vin: 128'h0103_0700,   exp: 5'b01010};
        tv[5] = '{vin: 128'hFFFF_FFDF,   exp: 5'b00001};
        for (int i = 0; i < 6; i++) begin
            infer(tv[i].vin, r);
            check("table_low5", 128'(r[4:0]), 128'(tv[i].exp));
            check("table_model", 128'(r), 128'(model(tv[i].vin)));
        end

        for (int i = 0; i < 200; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            infer(v, r);
            for (int k = 0; k < 4; k++) par[k] = ^v[8*k +: 8];
            check("rand_parity", 128'(r[3:0]), 128'(par));
            check("rand_model", 128'(r), 128'(model(v)));
        end

        // Latency/busy profile, then back-pressure while parked in HOLD.
        v = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        busy_cnt = 0; first_busy = -1; first_ov = -1; irdy_bad = 0;
        for (int k = 0; k <= NEURONS + 4; k++) begin
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = k;
                if (bus.in_ready) irdy_bad++;
            end
            if (bus.out_valid && first_ov < 0) first_ov = k;
            if (k < NEURONS + 4) @(negedge clk);
        end
        check("busy_cycles", 128'(busy_cnt), 128'(NEURONS + 1));
        check("busy_first_edge", 128'(first_busy), 128'd1);
        check("out_valid_edge", 128'(first_ov), 128'(NEURONS + 2));
        check("in_ready_while_busy", 128'(irdy_bad), 128'd0);
        exp_r = model(v);
        check("latency_data", 128'(bus.out_data), 128'(exp_r));

        v2 = {$urandom, $urandom, $urandom, ~$urandom};
        bus.in_valid = 1'b1; bus.in_data = v2;
        stable_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== exp_r || bus.in_ready) stable_bad++;
        end
        check("backpressure_stable", 128'(stable_bad), 128'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_out_valid_drop", 128'(bus.out_valid), 128'd0);
        check("bp_in_ready_back", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 128'(bus.in_ready), 128'd0);
        wait_out("bp_timeout");
        check("bp_next_data", 128'(bus.out_data), 128'(model(v2)));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

`ifdef LUT_SEQ_CFG_LOCK_EN
        // Write during EVAL must be dropped and flagged once.
        v = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = 7'd1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("lock_err_pulse", 128'(cfg_err), 128'd1);
        @(negedge clk);
        check("lock_err_single", 128'(cfg_err), 128'd0);
        wait_out("lock_timeout");
        check("lock_data", 128'(bus.out_data), 128'(model(v)));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        infer('0, r);
        check("lock_readback", 128'(r[0]), 128'd0);
`else
        // Write in IDLE applies; no error flag in this build.
        cfg_wr(1'b1, 0, 0, 1);
        cfg_done();
        check("cfg_err_tied", 128'(cfg_err), 128'd0);
        m_tbl[0][0] = 1'b1;
        infer('0, r);
        check("cfg_idle_write", 128'(r[0]), 128'd1);
        check("cfg_idle_model", 128'(r), 128'(model('0)));
        cfg_wr(1'b1, 0, 0, 0);
        cfg_done();
        m_tbl[0][0] = 1'b0;
`endif

        // Reset mid-EVAL: outputs clear at once, configuration survives.
        v = {$urandom, $urandom, $urandom, $urandom};
        infer(v, r);
        check("pre_reset_model", 128'(r), 128'(model(v)));
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = ~v;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        check("midrst_out_data", 128'(bus.out_data), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        v2 = {$urandom, $urandom, $urandom, $urandom};
        infer(v2, r);
        check("postrst_model", 128'(r), 128'(model(v2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
